// File: rtl/rmt_egress_arb.sv
// Packet-granularity round-robin merge of S_COUNT AXI-Stream sources onto one
// egress stream. Ports: clk/rst, s_axis_* (S_COUNT packed), m_axis_*, busy.
module rmt_egress_arb #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 8,
  parameter int ID_WIDTH   = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [ID_WIDTH:0]   idx;
  logic                found;

  logic                  buf_ready_q, buf_ready_d;
  logic                  in_beat, in_valid, in_last;
  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic [USER_WIDTH-1:0] in_user;

  logic                  m_valid_q, m_last_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0] m_keep_q;
  logic [USER_WIDTH-1:0] m_user_q;
  logic [ID_WIDTH-1:0]   m_id_q;
  logic                  t_valid_q, t_last_q;
  logic [DATA_WIDTH-1:0] t_data_q;
  logic [KEEP_WIDTH-1:0] t_keep_q;
  logic [USER_WIDTH-1:0] t_user_q;
  logic [ID_WIDTH-1:0]   t_id_q;

  // Granted-source mux
  always_comb begin
    in_data  = '0;
    in_keep  = '0;
    in_user  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        in_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        in_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        in_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        in_valid = s_axis_tvalid[i];
        in_last  = s_axis_tlast[i];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == ACTIVE) begin
      for (int i = 0; i < S_COUNT; i++) begin
        if (grant_q == ID_WIDTH'(i)) s_axis_tready[i] = buf_ready_q;
      end
    end
  end

  assign in_beat = (state_q == ACTIVE) && in_valid && buf_ready_q;
  assign busy    = (state_q == ACTIVE);

  // Arbitration: search upward from last_grant+1 with wrap
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    idx          = '0;
    unique case (state_q)
      IDLE: begin
        for (int i = 1; i <= S_COUNT; i++) begin
          idx = {1'b0, last_grant_q} + (ID_WIDTH+1)'(i);
          if (idx >= (ID_WIDTH+1)'(S_COUNT))
            idx = idx - (ID_WIDTH+1)'(S_COUNT);
          if (!found && s_axis_tvalid[idx[ID_WIDTH-1:0]]) begin
            found   = 1'b1;
            grant_d = idx[ID_WIDTH-1:0];
          end
        end
        if (found) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (in_beat && in_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(S_COUNT - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Skid buffer: ready is registered, so temp catches the beat
  // accepted in the cycle the downstream stalls.
  assign buf_ready_d = m_axis_tready ||
                       (!t_valid_q && (!m_valid_q || !in_beat));

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_ready_q <= 1'b0;
      m_valid_q   <= 1'b0;
      t_valid_q   <= 1'b0;
    end else begin
      buf_ready_q <= buf_ready_d;
      if (buf_ready_q) begin
        if (m_axis_tready || !m_valid_q) begin
          m_valid_q <= in_beat;
          if (in_beat) begin
            m_data_q <= in_data;
            m_keep_q <= in_keep;
            m_user_q <= in_user;
            m_last_q <= in_last;
            m_id_q   <= grant_q;
          end
        end else begin
          t_valid_q <= in_beat;
          if (in_beat) begin
            t_data_q <= in_data;
            t_keep_q <= in_keep;
            t_user_q <= in_user;
            t_last_q <= in_last;
            t_id_q   <= grant_q;
          end
        end
      end else if (m_axis_tready) begin
        m_valid_q <= t_valid_q;
        t_valid_q <= 1'b0;
        m_data_q  <= t_data_q;
        m_keep_q  <= t_keep_q;
        m_user_q  <= t_user_q;
        m_last_q  <= t_last_q;
        m_id_q    <= t_id_q;
      end
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tid    = m_id_q;

endmodule

// File: tb/tb_rmt_egress_arb.sv
// Bench for rmt_egress_arb: scoreboard of expected egress beats,
// two source drivers, toggled downstream ready.
module tb_rmt_egress_arb;
  localparam int S  = 2;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 8;
  localparam int IW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [S*DW-1:0] s_axis_tdata;
  logic [S*KW-1:0] s_axis_tkeep;
  logic [S-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [S*UW-1:0] s_axis_tuser;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [UW-1:0]   m_axis_tuser;
  logic [IW-1:0]   m_axis_tid;
  logic            busy;

  logic [DW-1:0] sd [S];
  logic [KW-1:0] sk [S];
  logic [UW-1:0] su [S];
  logic          sv [S];
  logic          sl [S];

  assign s_axis_tdata  = {sd[1], sd[0]};
  assign s_axis_tkeep  = {sk[1], sk[0]};
  assign s_axis_tuser  = {su[1], su[0]};
  assign s_axis_tvalid = {sv[1], sv[0]};
  assign s_axis_tlast  = {sl[1], sl[0]};

  rmt_egress_arb #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tid(m_axis_tid), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    logic [IW-1:0] id;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit p0_done = 1'b0;

  task automatic chk(input string tag, input logic [639:0] got,
                     input logic [639:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int p, input int n, input int base,
                            input logic [KW-1:0] keep);
    for (int b = 0; b < n; b++) begin
      beat_t e;
      e.d  = DW'(base + b);
      e.k  = keep;
      e.u  = UW'(base + b);
      e.l  = (b == n - 1);
      e.id = IW'(p);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int p, input int n, input int base,
                      input logic [KW-1:0] keep, input int gap_at,
                      input int gap_len);
    for (int b = 0; b < n; b++) begin
      bit got;
      int t;
      if (b == gap_at) begin
        sv[p] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      sd[p] = DW'(base + b);
      sk[p] = keep;
      su[p] = UW'(base + b);
      sl[p] = (b == n - 1);
      sv[p] = 1'b1;
      got = 1'b0;
      t = 0;
      while (!got && t < 300) begin
        @(negedge clk);
        got = s_axis_tready[p];
        @(posedge clk);
        #1;
        t++;
      end
      if (!got) begin
        chk("accept_timeout", {639'b0, got}, 640'd1);
        break;
      end
    end
    sv[p] = 1'b0;
    sl[p] = 1'b0;
  endtask

  // Egress monitor
  logic         hold;
  logic [639:0] saved;
  int           abs_n;
  wire  [639:0] outs = {54'b0, m_axis_tdata, m_axis_tkeep, m_axis_tuser,
                        m_axis_tlast, m_axis_tid};
  wire          acc  = |(s_axis_tvalid & s_axis_tready);

  initial begin
    hold = 1'b0;
    saved = '0;
    abs_n = 0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold) chk("stall_stable", outs, saved);
      hold  <= m_axis_tvalid && !m_axis_tready;
      saved <= outs;
      if (!m_axis_tready && acc)
        chk("absorb_le2", {639'b0, (abs_n + 1) <= 2}, 640'd1);
      abs_n <= m_axis_tready ? 0 : abs_n + int'(acc);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", {639'b0, m_axis_tvalid}, 640'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("data", {128'b0, m_axis_tdata}, {128'b0, e.d});
          chk("keep", {576'b0, m_axis_tkeep}, {576'b0, e.k});
          chk("user", {632'b0, m_axis_tuser}, {632'b0, e.u});
          chk("last", {639'b0, m_axis_tlast}, {639'b0, e.l});
          chk("tid", {639'b0, m_axis_tid}, {639'b0, e.id});
        end
      end
    end else begin
      hold  <= 1'b0;
      abs_n <= 0;
    end
  end

  initial begin
    for (int p = 0; p < S; p++) begin
      sd[p] = '0; sk[p] = '0; su[p] = '0; sv[p] = 1'b0; sl[p] = 1'b0;
    end
    rst = 1'b1;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {639'b0, m_axis_tvalid}, 640'd0);
    chk("rst_ready", {638'b0, s_axis_tready}, 640'd0);
    chk("rst_busy", {639'b0, busy}, 640'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {638'b0, s_axis_tready}, 640'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Two ports, two 3-beat frames each: A,B,A,B
    push_frame(0, 3, 'h100, '1);
    push_frame(1, 3, 'h200, '1);
    push_frame(0, 3, 'h110, '1);
    push_frame(1, 3, 'h210, '1);
    fork
      begin send(0, 3, 'h100, '1, -1, 0); send(0, 3, 'h110, '1, -1, 0); end
      begin send(1, 3, 'h200, '1, -1, 0); send(1, 3, 'h210, '1, -1, 0); end
    join
    repeat (3) @(posedge clk);
    #1;

    // Single 4-beat frame on port 0, latency and busy
    push_frame(0, 4, 'h10, '1);
    fork
      send(0, 4, 'h10, '1, -1, 0);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("lat_v1", {639'b0, m_axis_tvalid}, 640'd0);
        chk("lat_busy", {639'b0, busy}, 640'd1);
        @(negedge clk);
        chk("lat_v2", {639'b0, m_axis_tvalid}, 640'd1);
      end
    join
    chk("busy_end", {639'b0, busy}, 640'd0);
    repeat (2) @(posedge clk);
    #1;

    // Single-beat frame on port 1
    push_frame(1, 1, 'h300, 64'h0000_0000_0000_00FF);
    send(1, 1, 'h300, 64'h0000_0000_0000_00FF, -1, 0);
    chk("single_idle", {639'b0, busy}, 640'd0);
    repeat (2) @(posedge clk);
    #1;

    // 8-beat frame under ready pattern 1,0,0,1
    push_frame(0, 8, 'h400, '1);
    fork
      send(0, 8, 'h400, '1, -1, 0);
      begin
        for (int c = 0; c < 60; c++) begin
          m_axis_tready = (c % 4 == 0) || (c % 4 == 3);
          @(posedge clk);
          #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Port 0 pauses mid-frame; port 1 must wait
    push_frame(0, 6, 'h500, '1);
    push_frame(1, 2, 'h600, '1);
    p0_done = 1'b0;
    fork
      begin send(0, 6, 'h500, '1, 2, 5); p0_done = 1'b1; end
      begin repeat (3) @(posedge clk); #1; send(1, 2, 'h600, '1, -1, 0); end
      begin
        int bad;
        int t;
        bad = 0;
        t = 0;
        while (!p0_done && t < 300) begin
          @(negedge clk);
          if (!p0_done && s_axis_tready[1]) bad++;
          t++;
        end
        chk("hold_grant", 640'(bad), 640'd0);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-frame
    push_frame(0, 1, 'h700, '1);
    send(0, 1, 'h700, '1, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    sd[0] = DW'('h7A0); sk[0] = '1; su[0] = 8'hA0; sl[0] = 1'b0;
    sv[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_valid", {639'b0, m_axis_tvalid}, 640'd0);
    chk("rstmid_ready", {638'b0, s_axis_tready}, 640'd0);
    chk("rstmid_busy", {639'b0, busy}, 640'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    push_frame(0, 2, 'h800, '1);
    push_frame(1, 2, 'h900, '1);
    fork
      send(0, 2, 'h800, '1, -1, 0);
      send(1, 2, 'h900, '1, -1, 0);
    join

    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain", 640'(exp_q.size()), 640'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
